// File: rtl/pingpong_frame_bram_pkg.sv
// Shared definitions for the ping-pong frame buffer.
// Provides the default word width and depth used by the FFT pipeline, and
// the packed real/imag word layout stored in each bank.
// No ports (package).

`ifndef SFFT_OUTPUT_WIDTH
`define SFFT_OUTPUT_WIDTH 16
`endif
`ifndef NFFT
`define NFFT 64
`endif

package pingpong_frame_bram_pkg;

    localparam int unsigned SFFT_OUTPUT_WIDTH = `SFFT_OUTPUT_WIDTH;
    localparam int unsigned FRAME_DEPTH       = `NFFT;

    typedef struct packed {
        logic signed [SFFT_OUTPUT_WIDTH-1:0] re;
        logic signed [SFFT_OUTPUT_WIDTH-1:0] im;
    } frame_word_t;

    localparam int unsigned FRAME_WIDTH = $bits(frame_word_t);

endpackage

// File: rtl/pingpong_frame_bram_sdp_bank.sv
// Simple dual-port RAM bank: one write port, one registered read port.
// Ports:
//   clk, reset_n     - clock, async active-low reset (read register only)
//   we, waddr, wdata - write port
//   re, raddr        - read strobe and address
//   rdata            - registered read data, holds when re=0
// The array itself has no reset so it maps onto block RAM.

module sdp_bank #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Output register reset maps onto the RAM's output-latch reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/pingpong_frame_bram.sv
// Double-buffered (ping-pong) frame buffer between FFT pipeline stages.
// Ports:
//   clk, reset_n, flush           - clock, async reset, sync frame-state clear
//   a_addr/a_wdata/a_we/a_commit  - producer: write frame, then commit bank
//   a_ready, a_bank               - write bank free / its index
//   b_addr/b_re/b_release         - consumer: read frame, then release bank
//   b_avail, b_bank               - read bank holds a frame / its index
//   b_rdata, b_rvalid             - read data, valid RD_LAT cycles after b_re
//   err_ovf, err_udf              - sticky misuse flags

module pingpong_frame_bram
    import pingpong_frame_bram_pkg::*;
#(
    parameter int unsigned WIDTH  = FRAME_WIDTH,
    parameter int unsigned DEPTH  = FRAME_DEPTH,
    parameter int unsigned ADDR_W = $clog2(DEPTH),
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [WIDTH-1:0]  a_wdata,
    input  logic              a_we,
    input  logic              a_commit,
    output logic              a_ready,
    output logic              a_bank,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic              b_re,
    input  logic              b_release,
    output logic              b_avail,
    output logic              b_bank,
    output logic [WIDTH-1:0]  b_rdata,
    output logic              b_rvalid,
    output logic              err_ovf,
    output logic              err_udf
);

    logic       wr_bank;
    logic       rd_bank;
    logic [1:0] full;
    logic [1:0] full_next;
    logic       wr_ok;
    logic       rd_ok;
    logic       commit_ok;
    logic       rel_ok;

    assign a_ready = ~full[wr_bank];
    assign b_avail = full[rd_bank];
    assign a_bank  = wr_bank;
    assign b_bank  = rd_bank;

    // flush also blocks the RAM ports so memory and b_rdata stay untouched.
    assign wr_ok     = a_we & a_ready & ~flush;
    assign rd_ok     = b_re & b_avail & ~flush;
    assign commit_ok = a_commit & a_ready;
    assign rel_ok    = b_release & b_avail;

    // commit_ok and rel_ok always address different banks (one is empty,
    // the other full), so both updates can apply in the same cycle.
    always_comb begin
        full_next = full;
        if (commit_ok) full_next[wr_bank] = 1'b1;
        if (rel_ok)    full_next[rd_bank] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            full    <= '0;
            err_ovf <= 1'b0;
            err_udf <= 1'b0;
        end else if (flush) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            full    <= '0;
            err_ovf <= 1'b0;
            err_udf <= 1'b0;
        end else begin
            full    <= full_next;
            wr_bank <= wr_bank ^ commit_ok;
            rd_bank <= rd_bank ^ rel_ok;
            err_ovf <= err_ovf | ((a_we | a_commit) & ~a_ready);
            err_udf <= err_udf | ((b_re | b_release) & ~b_avail);
        end
    end

    logic [WIDTH-1:0] bank_rdata [2];

    for (genvar g = 0; g < 2; g++) begin : g_bank
        sdp_bank #(
            .WIDTH  (WIDTH),
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
        ) u_bank (
            .clk     (clk),
            .reset_n (reset_n),
            .we      (wr_ok & (wr_bank == 1'(g))),
            .waddr   (a_addr),
            .wdata   (a_wdata),
            .re      (rd_ok & (rd_bank == 1'(g))),
            .raddr   (b_addr),
            .rdata   (bank_rdata[g])
        );
    end

    // rd_sel remembers which bank the last accepted read came from, so reads
    // in flight across a release still return the released bank's data.
    logic             rd_sel;
    logic             s1_valid;
    logic [WIDTH-1:0] s1_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_sel   <= 1'b0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= rd_ok;
            if (rd_ok) rd_sel <= rd_bank;
        end
    end

    assign s1_data = rd_sel ? bank_rdata[1] : bank_rdata[0];

    if (RD_LAT == 2) begin : g_lat2
        logic             s2_valid;
        logic [WIDTH-1:0] s2_data;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                s2_valid <= 1'b0;
                s2_data  <= '0;
            end else begin
                s2_valid <= s1_valid & ~flush;
                if (s1_valid && !flush) s2_data <= s1_data;
            end
        end

        assign b_rdata  = s2_data;
        assign b_rvalid = s2_valid;
    end else begin : g_lat1
        assign b_rdata  = s1_data;
        assign b_rvalid = s1_valid;
    end

endmodule

// File: tb/tb_pingpong_frame_bram.sv
// Self-checking bench for pingpong_frame_bram: one RD_LAT=1 and one RD_LAT=2
// instance share stimulus; both are compared against a frame-level model.

module tb_pingpong_frame_bram;

    localparam int W  = 32;
    localparam int D  = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          flush = 1'b0;
    logic [AW-1:0] a_addr = '0;
    logic [W-1:0]  a_wdata = '0;
    logic          a_we = 1'b0;
    logic          a_commit = 1'b0;
    logic [AW-1:0] b_addr = '0;
    logic          b_re = 1'b0;
    logic          b_release = 1'b0;

    logic          a_ready1, a_bank1, b_avail1, b_bank1, b_rvalid1, err_ovf1, err_udf1;
    logic [W-1:0]  b_rdata1;
    logic          a_ready2, a_bank2, b_avail2, b_bank2, b_rvalid2, err_ovf2, err_udf2;
    logic [W-1:0]  b_rdata2;

    always #5 clk = ~clk;

    pingpong_frame_bram #(.WIDTH(W), .DEPTH(D), .RD_LAT(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .a_addr(a_addr), .a_wdata(a_wdata), .a_we(a_we), .a_commit(a_commit),
        .a_ready(a_ready1), .a_bank(a_bank1),
        .b_addr(b_addr), .b_re(b_re), .b_release(b_release),
        .b_avail(b_avail1), .b_bank(b_bank1), .b_rdata(b_rdata1), .b_rvalid(b_rvalid1),
        .err_ovf(err_ovf1), .err_udf(err_udf1)
    );

    pingpong_frame_bram #(.WIDTH(W), .DEPTH(D), .RD_LAT(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .a_addr(a_addr), .a_wdata(a_wdata), .a_we(a_we), .a_commit(a_commit),
        .a_ready(a_ready2), .a_bank(a_bank2),
        .b_addr(b_addr), .b_re(b_re), .b_release(b_release),
        .b_avail(b_avail2), .b_bank(b_bank2), .b_rdata(b_rdata2), .b_rvalid(b_rvalid2),
        .err_ovf(err_ovf2), .err_udf(err_udf2)
    );

    int checks = 0;
    int failures = 0;

    // Frame-level model: banks are used round-robin, so the write bank is the
    // commit count mod 2, the read bank the release count mod 2, and the
    // number of full banks is their difference.
    logic [W-1:0] m_mem [2][D];
    int           m_commits = 0;
    int           m_releases = 0;
    bit           m_ovf = 0;
    bit           m_udf = 0;
    bit           m_v1 = 0;
    logic [W-1:0] m_d1 = '0;
    bit           m_v2 = 0;
    logic [W-1:0] m_d2 = '0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        int nf;
        nf = m_commits - m_releases;
        chk("a_ready1",  W'(a_ready1),  W'(nf < 2));
        chk("b_avail1",  W'(b_avail1),  W'(nf > 0));
        chk("a_bank1",   W'(a_bank1),   W'(m_commits % 2));
        chk("b_bank1",   W'(b_bank1),   W'(m_releases % 2));
        chk("err_ovf1",  W'(err_ovf1),  W'(m_ovf));
        chk("err_udf1",  W'(err_udf1),  W'(m_udf));
        chk("b_rvalid1", W'(b_rvalid1), W'(m_v1));
        chk("b_rdata1",  b_rdata1,      m_d1);
        chk("a_ready2",  W'(a_ready2),  W'(nf < 2));
        chk("b_bank2",   W'(b_bank2),   W'(m_releases % 2));
        chk("err_udf2",  W'(err_udf2),  W'(m_udf));
        chk("b_rvalid2", W'(b_rvalid2), W'(m_v2));
        chk("b_rdata2",  b_rdata2,      m_d2);
    endtask

    // One clock: sample inputs, advance the model across the edge, compare.
    task automatic tick();
        int           nf, wb, rb;
        bit           ar, ba, rv, pv1;
        logic [W-1:0] rdv, pd1;
        nf  = m_commits - m_releases;
        ar  = (nf < 2);
        ba  = (nf > 0);
        wb  = m_commits % 2;
        rb  = m_releases % 2;
        rv  = b_re && ba && !flush;
        rdv = m_mem[rb][b_addr];
        pv1 = m_v1;
        pd1 = m_d1;
        @(posedge clk);
        if (flush) begin
            m_commits = 0;
            m_releases = 0;
            m_ovf = 0;
            m_udf = 0;
            m_v1 = 0;
            m_v2 = 0;
        end else begin
            if (a_we && ar) m_mem[wb][a_addr] = a_wdata;
            if ((a_we || a_commit) && !ar) m_ovf = 1;
            if ((b_re || b_release) && !ba) m_udf = 1;
            if (a_commit && ar) m_commits++;
            if (b_release && ba) m_releases++;
            m_v1 = rv;
            if (rv) m_d1 = rdv;
            m_v2 = pv1;
            if (pv1) m_d2 = pd1;
        end
        #1;
        check_all();
    endtask

    task automatic idle();
        flush = 0; a_we = 0; a_commit = 0; b_re = 0; b_release = 0;
    endtask

    task automatic model_reset();
        m_commits = 0; m_releases = 0; m_ovf = 0; m_udf = 0;
        m_v1 = 0; m_v2 = 0; m_d1 = '0; m_d2 = '0;
    endtask

    task automatic write_frame(input logic [W-1:0] base);
        for (int i = 0; i < D; i++) begin
            idle(); a_we = 1; a_addr = AW'(i); a_wdata = base + W'(i);
            tick();
        end
        idle(); a_commit = 1;
        tick();
        idle();
    endtask

    // Called just after a posedge: drops reset mid-cycle, checks immediately.
    task automatic async_reset();
        idle();
        #3 reset_n = 0;
        #1 model_reset();
        check_all();
        @(negedge clk) reset_n = 1;
        tick();
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] waddr;
        logic [W-1:0]  wdata;
        logic          commit;
        logic          re;
        logic [AW-1:0] raddr;
        logic          rel;
        logic          e_ready;
        logic          e_avail;
        logic          e_rvalid;
        logic [W-1:0]  e_rdata;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic we, int waddr, logic [W-1:0] wdata, logic commit,
                                logic re, int raddr, logic rel,
                                logic e_ready, logic e_avail, logic e_rvalid,
                                logic [W-1:0] e_rdata);
        vec_t v;
        v.we = we; v.waddr = AW'(waddr); v.wdata = wdata; v.commit = commit;
        v.re = re; v.raddr = AW'(raddr); v.rel = rel;
        v.e_ready = e_ready; v.e_avail = e_avail; v.e_rvalid = e_rvalid; v.e_rdata = e_rdata;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        int first_v2, n_v2;

        // First frame: write 0x100+i, commit, read back 7..0, release, underflow.
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0));
        for (int i = 0; i < D; i++)
            tbl.push_back(mk(1, i, 32'h100 + W'(i), 0, 0, 0, 0, 1, 0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 32'h0));
        for (int i = 0; i < D; i++)
            tbl.push_back(mk(0, 0, 0, 0, 1, 7 - i, 0, 1, 1, 1, 32'h107 - W'(i)));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h100));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 32'h100));
        tbl.push_back(mk(0, 0, 0, 0, 1, 2, 0, 1, 0, 0, 32'h100));

        // Reset state, checked while reset is still asserted and after release.
        idle();
        #1 check_all();
        @(negedge clk) reset_n = 1;
        tick();

        foreach (tbl[k]) begin
            idle();
            a_we = tbl[k].we; a_addr = tbl[k].waddr; a_wdata = tbl[k].wdata;
            a_commit = tbl[k].commit; b_re = tbl[k].re; b_addr = tbl[k].raddr;
            b_release = tbl[k].rel;
            tick();
            chk("tbl_a_ready",  W'(a_ready1),  W'(tbl[k].e_ready));
            chk("tbl_b_avail",  W'(b_avail1),  W'(tbl[k].e_avail));
            chk("tbl_b_rvalid", W'(b_rvalid1), W'(tbl[k].e_rvalid));
            chk("tbl_b_rdata",  b_rdata1,      tbl[k].e_rdata);
        end
        chk("udf_after_empty_read", W'(err_udf1), 32'h1);
        idle(); flush = 1; tick(); idle();

        // Back-pressure: two committed frames, then a dropped write.
        write_frame(32'hA0);
        write_frame(32'hB0);
        chk("bp_a_ready", W'(a_ready1), 32'h0);
        a_we = 1; a_addr = 0; a_wdata = 32'hDEAD;
        tick(); idle();
        chk("bp_err_ovf", W'(err_ovf1), 32'h1);
        for (int i = 0; i < D; i++) begin
            b_re = 1; b_addr = AW'(i);
            tick();
            chk("bp_frame_a", b_rdata1, 32'hA0 + W'(i));
        end
        idle(); b_release = 1; tick(); idle();
        chk("bp_b_bank", W'(b_bank1), 32'h1);

        // Eight back-to-back reads of frame B; RD_LAT=2 pulses start one tick later.
        first_v2 = -1; n_v2 = 0;
        for (int t = 0; t < D + 3; t++) begin
            idle();
            if (t < D) begin b_re = 1; b_addr = AW'(t); end
            tick();
            if (t < D) chk("lat1_frame_b", b_rdata1, 32'hB0 + W'(t));
            if (b_rvalid2) begin
                if (first_v2 < 0) first_v2 = t;
                chk("lat2_frame_b", b_rdata2, 32'hB0 + W'(n_v2));
                n_v2++;
            end
        end
        chk("lat2_first_pulse", W'(first_v2), 32'd1);
        chk("lat2_pulse_count", W'(n_v2), 32'd8);

        // Release frame B, then release again while empty.
        idle(); b_release = 1; tick();
        idle(); b_release = 1; tick(); idle();
        chk("udf_empty_release", W'(err_udf1), 32'h1);

        // Commit and release in the same cycle from full=01, wr=1, rd=0.
        idle(); flush = 1; tick(); idle();
        write_frame(32'h50);
        a_commit = 1; b_release = 1;
        tick(); idle();
        chk("cr_a_bank",  W'(a_bank1),  32'h0);
        chk("cr_b_bank",  W'(b_bank1),  32'h1);
        chk("cr_a_ready", W'(a_ready1), 32'h1);
        chk("cr_b_avail", W'(b_avail1), 32'h1);

        // Flush with a read in flight on both instances.
        b_re = 1; b_addr = 3; tick(); idle();
        flush = 1; tick(); idle();
        chk("flush_rvalid2", W'(b_rvalid2), 32'h0);
        chk("flush_b_avail", W'(b_avail1),  32'h0);

        // Asynchronous reset mid-frame.
        write_frame(32'h70);
        a_we = 1; a_addr = 2; a_wdata = 32'h1234; tick();
        a_addr = 5; tick();
        async_reset();
        chk("rst_a_ready", W'(a_ready1), 32'h1);
        chk("rst_b_avail", W'(b_avail1), 32'h0);

        // Randomised traffic: all memory locations already hold known data.
        for (int t = 0; t < 600; t++) begin
            idle();
            a_we      = 1'($urandom_range(0, 1));
            a_addr    = AW'($urandom_range(0, D - 1));
            a_wdata   = $urandom;
            a_commit  = ($urandom_range(0, 5) == 0);
            b_re      = 1'($urandom_range(0, 1));
            b_addr    = AW'($urandom_range(0, D - 1));
            b_release = ($urandom_range(0, 5) == 0);
            flush     = ($urandom_range(0, 79) == 0);
            tick();
        end
        idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
